// File: rtl/stepper_phase_decoder.sv
// Read-back decoder for the stepper coil lines: position, direction, period, fault.
// Define HALF_STEP_EN to accept the four two-coil patterns as half steps.
module stepper_phase_decoder #(
   parameter int POS_W       = 32,
   parameter int PER_W       = 24,
   parameter int FILT_LEN    = 4,
   parameter int IDLE_CYCLES = 5000000
) (
   input  logic                    clock,
   input  logic                    Reset,
   input  logic [3:0]              Phase,
   input  logic                    Clear,
   output logic signed [POS_W-1:0] Position,
   output logic                    Direction,
   output logic                    StepPulse,
   output logic [PER_W-1:0]        StepPeriod,
   output logic                    PeriodValid,
   output logic                    Moving,
   output logic                    Fault
);

`ifdef HALF_STEP_EN
   localparam int IDX_W = 3;
`else
   localparam int IDX_W = 2;
`endif

   localparam logic [7:0]       FILT_MAX = 8'(FILT_LEN);
   localparam logic [PER_W-1:0] PER_SAT  = '1;
   localparam logic [31:0]      IDLE_LIM = 32'(IDLE_CYCLES);

   typedef enum logic {
      ACQUIRE = 1'b0,
      TRACK   = 1'b1
   } state_t;

   state_t state;
   state_t state_nx;

   logic [3:0]       ph_s1;
   logic [3:0]       ph_s2;
   logic [3:0]       cand;
   logic [7:0]       filt_cnt;
   logic             acc_stb;

   logic             pat_legal;
   logic             pat_bad;
   logic [IDX_W-1:0] pat_idx;
   logic [IDX_W-1:0] last_idx;
   logic [IDX_W-1:0] idx_diff;
   logic             is_fwd;
   logic             is_rev;
   logic             is_skip;

   logic             idx_load;
   logic             step_fwd;
   logic             step_rev;
   logic             fault_set;
   logic             step;

   logic [PER_W-1:0]        per_cnt;
   logic                    seen_step;
   logic                    idle_hit;
   logic signed [POS_W-1:0] pos_nx;

   always_ff @(posedge clock) begin
      if (Reset) begin
         ph_s1 <= '0;
         ph_s2 <= '0;
      end else begin
         ph_s1 <= Phase;
         ph_s2 <= ph_s1;
      end
   end

   // acc_stb fires once, the cycle a candidate completes FILT_LEN stable cycles
   always_ff @(posedge clock) begin
      if (Reset) begin
         cand     <= '0;
         filt_cnt <= '0;
         acc_stb  <= 1'b0;
      end else if (ph_s2 != cand) begin
         cand     <= ph_s2;
         filt_cnt <= 8'd1;
         acc_stb  <= (FILT_LEN == 1);
      end else if (filt_cnt < FILT_MAX) begin
         filt_cnt <= filt_cnt + 8'd1;
         acc_stb  <= (filt_cnt + 8'd1 == FILT_MAX);
      end else begin
         acc_stb  <= 1'b0;
      end
   end

   always_comb begin
      pat_legal = 1'b1;
      pat_idx   = '0;
      case (cand)
`ifdef HALF_STEP_EN
         4'b0001: pat_idx = 3'd0;
         4'b0011: pat_idx = 3'd1;
         4'b0010: pat_idx = 3'd2;
         4'b0110: pat_idx = 3'd3;
         4'b0100: pat_idx = 3'd4;
         4'b1100: pat_idx = 3'd5;
         4'b1000: pat_idx = 3'd6;
         4'b1001: pat_idx = 3'd7;
`else
         4'b0001: pat_idx = 2'd0;
         4'b0010: pat_idx = 2'd1;
         4'b0100: pat_idx = 2'd2;
         4'b1000: pat_idx = 2'd3;
`endif
         default: pat_legal = 1'b0;
      endcase
      pat_bad = !pat_legal && (cand != 4'b0000);
   end

   // index arithmetic wraps naturally modulo the sequence length
   assign idx_diff = pat_idx - last_idx;
   assign is_fwd   = (idx_diff == IDX_W'(1));
   assign is_rev   = (idx_diff == '1);
   assign is_skip  = (idx_diff != '0) && !is_fwd && !is_rev;

   always_ff @(posedge clock) begin
      if (Reset) state <= ACQUIRE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (acc_stb && pat_legal && state == ACQUIRE)
         state_nx = TRACK;
   end

   always_comb begin
      idx_load  = 1'b0;
      step_fwd  = 1'b0;
      step_rev  = 1'b0;
      fault_set = 1'b0;
      if (acc_stb && pat_legal) begin
         idx_load = 1'b1;
         if (state == TRACK) begin
            unique case (1'b1)
               is_fwd:  step_fwd  = 1'b1;
               is_rev:  step_rev  = 1'b1;
               is_skip: fault_set = 1'b1;
               default: ;
            endcase
         end
      end
      if (acc_stb && pat_bad)
         fault_set = 1'b1;
   end

   assign step     = step_fwd | step_rev;
   assign idle_hit = (32'(per_cnt) >= IDLE_LIM);

   // a step coinciding with Clear lands on top of the cleared value
   always_comb begin
      pos_nx = Clear ? '0 : Position;
      if (step_fwd) pos_nx = pos_nx + POS_W'(1);
      if (step_rev) pos_nx = pos_nx - POS_W'(1);
   end

   always_ff @(posedge clock) begin
      if (Reset) begin
         last_idx    <= '0;
         Position    <= '0;
         Direction   <= 1'b0;
         StepPulse   <= 1'b0;
         Fault       <= 1'b0;
         per_cnt     <= '0;
         StepPeriod  <= '0;
         PeriodValid <= 1'b0;
         Moving      <= 1'b0;
         seen_step   <= 1'b0;
      end else begin
         if (idx_load) last_idx <= pat_idx;
         Position  <= pos_nx;
         StepPulse <= step;
         Fault     <= (Fault & ~Clear) | fault_set;
         if (step) begin
            Direction   <= step_fwd;
            per_cnt     <= PER_W'(1);
            StepPeriod  <= per_cnt;
            PeriodValid <= seen_step && (per_cnt != PER_SAT);
            Moving      <= 1'b1;
            seen_step   <= 1'b1;
         end else begin
            if (per_cnt != PER_SAT)
               per_cnt <= per_cnt + PER_W'(1);
            if (idle_hit) begin
               Moving      <= 1'b0;
               PeriodValid <= 1'b0;
            end
         end
      end
   end

endmodule
